// File: rtl/keypad_pkg.sv
// ============================================================================
// keypad_pkg : shared keypad encodings (entry, search and password stages)
// Rev 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int DEFAULT_DIGIT_W = 4;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    typedef enum logic [1:0] {
        COLLECT = ST_COLLECT,
        FULL    = ST_FULL,
        LOCKED  = ST_LOCKED
    } state_e;

    // Acting key after priority resolution, highest priority listed last.
    typedef enum logic [2:0] {
        KEY_NONE   = 3'd0,
        KEY_DIGIT  = 3'd1,
        KEY_ENTER  = 3'd2,
        KEY_BACK   = 3'd3,
        KEY_CLEAR  = 3'd4,
        KEY_LOGOUT = 3'd5
    } key_e;

    function automatic key_e key_select(
        input logic lo,
        input logic cl,
        input logic bk,
        input logic en,
        input logic dg
    );
        key_e k;
        k = KEY_NONE;
        if (lo)      k = KEY_LOGOUT;
        else if (cl) k = KEY_CLEAR;
        else if (bk) k = KEY_BACK;
        else if (en) k = KEY_ENTER;
        else if (dg) k = KEY_DIGIT;
        return k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/entry_idle_timer.sv
// ============================================================================
// entry_idle_timer : counts consecutive idle cycles, flags the TIMEOUT_CYC-th
// Rev 1.0
// ============================================================================
`default_nettype none

module entry_idle_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_idle;

    // expire marks the cycle that completes the idle window; the caller registers it.
    assign expire = run && !load && (r_idle == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
        end else if (load || !run || expire) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/userid_keypad_entry.sv
// ============================================================================
// userid_keypad_entry : assembles keypad digits into a user ID and locks it
// on ENTER. Optional idle timeout built when USERID_TIMEOUT_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module userid_keypad_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = DEFAULT_DIGIT_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic [DIGIT_W-1:0]           key_code,
    input  logic                         key_enter,
    input  logic                         key_back,
    input  logic                         key_clear,
    input  logic                         logout,
    output logic [DIGITS*DIGIT_W-1:0]    userid_entered,
    output logic                         valid,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         entry_err,
    output logic                         timeout
);

    localparam int ID_W  = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(DIGITS + 1);

    if (DIGITS < 2 || DIGIT_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("userid_keypad_entry: DIGITS>=2, DIGIT_W>=1, TIMEOUT_CYC>=1 required");
    end

    state_e           r_state;
    state_e           w_state_nxt;
    logic [ID_W-1:0]  w_id_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_valid_nxt;
    logic             w_err_nxt;
    logic             w_timeout_nxt;
    logic             w_expire;
    key_e             w_key;

    assign w_key = key_select(logout, key_clear, key_back, key_enter, key_valid);

`ifdef USERID_TIMEOUT_EN
    logic w_any_key;
    logic w_run;

    assign w_any_key = key_valid | key_enter | key_back | key_clear | logout;
    assign w_run     = ((r_state == COLLECT) || (r_state == FULL)) && (digit_count != '0);

    entry_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (w_any_key),
        .run    (w_run),
        .expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= COLLECT;
            userid_entered <= '0;
            digit_count    <= '0;
            valid          <= 1'b0;
            entry_err      <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            userid_entered <= w_id_nxt;
            digit_count    <= w_cnt_nxt;
            valid          <= w_valid_nxt;
            entry_err      <= w_err_nxt;
            timeout        <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_id_nxt      = userid_entered;
        w_cnt_nxt     = digit_count;
        w_valid_nxt   = valid;
        w_err_nxt     = 1'b0;
        w_timeout_nxt = 1'b0;

        case (r_state)
            COLLECT, FULL: begin
                w_valid_nxt = 1'b0;
                // A timeout can only fire on a cycle with no key strobe.
                if (w_expire) begin
                    w_state_nxt   = COLLECT;
                    w_id_nxt      = '0;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    case (w_key)
                        KEY_LOGOUT, KEY_CLEAR: begin
                            w_state_nxt = COLLECT;
                            w_id_nxt    = '0;
                            w_cnt_nxt   = '0;
                        end
                        KEY_BACK: begin
                            if (digit_count != '0) begin
                                w_state_nxt = COLLECT;
                                w_id_nxt    = userid_entered >> DIGIT_W;
                                w_cnt_nxt   = digit_count - CNT_W'(1);
                            end
                        end
                        KEY_ENTER: begin
                            if (r_state == FULL) begin
                                w_state_nxt = LOCKED;
                                w_valid_nxt = 1'b1;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                        KEY_DIGIT: begin
                            if (r_state == FULL) begin
                                w_err_nxt = 1'b1;
                            end else begin
                                w_id_nxt  = {userid_entered[ID_W-DIGIT_W-1:0], key_code};
                                w_cnt_nxt = digit_count + CNT_W'(1);
                                if (digit_count == CNT_W'(DIGITS - 1)) begin
                                    w_state_nxt = FULL;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            LOCKED: begin
                w_valid_nxt = 1'b1;
                if (w_key == KEY_LOGOUT) begin
                    w_state_nxt = COLLECT;
                    w_id_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = COLLECT;
                w_id_nxt    = '0;
                w_cnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_userid_keypad_entry.sv
// ============================================================================
// tb_userid_keypad_entry : directed + random bench with a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_userid_keypad_entry;

    localparam int DIGITS      = 4;
    localparam int DIGIT_W     = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int ID_W        = DIGITS * DIGIT_W;
    localparam int CNT_W       = $clog2(DIGITS + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               key_valid;
    logic [DIGIT_W-1:0] key_code;
    logic               key_enter;
    logic               key_back;
    logic               key_clear;
    logic               logout;
    logic [ID_W-1:0]    userid_entered;
    logic               valid;
    logic [CNT_W-1:0]   digit_count;
    logic               entry_err;
    logic               timeout;

    int checks   = 0;
    int failures = 0;

    // Model: digits held oldest-first, lock flag, pulse expectations.
    int q[$];
    bit m_locked   = 1'b0;
    bit m_err      = 1'b0;
    bit m_to       = 1'b0;
    int m_idle     = 0;
    bit model_on   = 1'b0;

    always #5 clk = ~clk;

    userid_keypad_entry #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_enter      (key_enter),
        .key_back       (key_back),
        .key_clear      (key_clear),
        .logout         (logout),
        .userid_entered (userid_entered),
        .valid          (valid),
        .digit_count    (digit_count),
        .entry_err      (entry_err),
        .timeout        (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_id();
        logic [31:0] id;
        id = 0;
        foreach (q[i]) id = id * (1 << DIGIT_W) + 32'(q[i]);
        return id & ((32'd1 << ID_W) - 1);
    endfunction

    task automatic model_clear();
        q.delete();
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_to     = 1'b0;
        m_idle   = 0;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit en, input bit bk,
                              input bit cl, input bit lo);
        bit any;
        int n_before;
        any      = kv | en | bk | cl | lo;
        n_before = q.size();
        m_err    = 1'b0;
        m_to     = 1'b0;
        if (m_locked) begin
            m_idle = 0;
            if (lo) begin
                m_locked = 1'b0;
                q.delete();
            end
        end else begin
`ifdef USERID_TIMEOUT_EN
            if (n_before > 0 && !any) begin
                m_idle++;
                if (m_idle == TIMEOUT_CYC) begin
                    q.delete();
                    m_to   = 1'b1;
                    m_idle = 0;
                end
            end else begin
                m_idle = 0;
            end
`else
            if (any || n_before == 0) m_idle = 0;
`endif
            if (lo || cl) q.delete();
            else if (bk) begin
                if (q.size() > 0) void'(q.pop_back());
            end else if (en) begin
                if (q.size() == DIGITS) m_locked = 1'b1;
                else m_err = 1'b1;
            end else if (kv) begin
                if (q.size() < DIGITS) q.push_back(kc);
                else m_err = 1'b1;
            end
        end
    endtask

    // Compare process: every cycle while the model is tracking.
    always @(negedge clk) begin
        if (model_on) begin
            check("userid",    32'(userid_entered), model_id());
            check("valid",     32'(valid),          32'(m_locked));
            check("count",     32'(digit_count),    32'(q.size()));
            check("entry_err", 32'(entry_err),      32'(m_err));
            check("timeout",   32'(timeout),        32'(m_to));
        end
    end

    task automatic step(input bit kv, input int kc, input bit en, input bit bk,
                        input bit cl, input bit lo);
        key_valid = kv;
        key_code  = DIGIT_W'(kc);
        key_enter = en;
        key_back  = bk;
        key_clear = cl;
        logout    = lo;
        @(posedge clk);
        model_step(kv, kc, en, bk, cl, lo);
        #1;
        key_valid = 1'b0;
        key_enter = 1'b0;
        key_back  = 1'b0;
        key_clear = 1'b0;
        logout    = 1'b0;
        key_code  = DIGIT_W'($urandom);
    endtask

    task automatic digit(input int d);  step(1, d, 0, 0, 0, 0); endtask
    task automatic enter();             step(0, 0, 1, 0, 0, 0); endtask
    task automatic back();              step(0, 0, 0, 1, 0, 0); endtask
    task automatic clr();               step(0, 0, 0, 0, 1, 0); endtask
    task automatic lgout();             step(0, 0, 0, 0, 0, 1); endtask
    task automatic idle();              step(0, 0, 0, 0, 0, 0); endtask

    // Asynchronous reset applied between edges; outputs must clear immediately.
    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_id0"},    32'(userid_entered), 0);
        check({tag, "_valid0"}, 32'(valid),          0);
        check({tag, "_cnt0"},   32'(digit_count),    0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = '0;
        key_enter = 1'b0;
        key_back  = 1'b0;
        key_clear = 1'b0;
        logout    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_id",    32'(userid_entered), 0);
        check("rst_valid", 32'(valid),          0);
        check("rst_count", 32'(digit_count),    0);
        check("rst_err",   32'(entry_err),      0);
        check("rst_to",    32'(timeout),        0);
        reset    = 1'b0;
        model_on = 1'b1;

        // 1: 1,2,3,4 then enter
        digit(1); digit(2); digit(3); digit(4);
        check("t1_id",       32'(userid_entered), 32'h1234);
        check("t1_model_id", model_id(),          32'h1234);
        check("t1_count",    32'(digit_count),    4);
        check("t1_valid_pre", 32'(valid),         0);
        enter();
        check("t1_valid",    32'(valid),          1);
        lgout();

        // 2: incomplete enter
        digit(10); digit(11); enter();
        check("t2_err",   32'(entry_err),      1);
        check("t2_valid", 32'(valid),          0);
        check("t2_id",    32'(userid_entered), 32'h00AB);
        check("t2_count", 32'(digit_count),    2);
        idle();
        check("t2_err_pulse", 32'(entry_err),  0);
        clr();

        // 3: overflow digit, back, replace, enter
        digit(1); digit(2); digit(3); digit(4); digit(5);
        check("t3_full_err", 32'(entry_err),      1);
        check("t3_full_id",  32'(userid_entered), 32'h1234);
        back();
        check("t3_back_id",  32'(userid_entered), 32'h0123);
        digit(9);
        check("t3_id",       32'(userid_entered), 32'h1239);
        enter();
        check("t3_valid",    32'(valid),          1);
        lgout();

        // 4: keys ignored in LOCKED, logout releases
        digit(1); digit(2); digit(3); digit(4); enter();
        digit(7);
        check("t4_dig_id",  32'(userid_entered), 32'h1234);
        check("t4_dig_err", 32'(entry_err),      0);
        clr();
        check("t4_clr_valid", 32'(valid),        1);
        lgout();
        check("t4_lo_valid", 32'(valid),          0);
        check("t4_lo_id",    32'(userid_entered), 0);

        // 5: priority
        digit(1);
        step(1, 5, 0, 0, 1, 0);
        check("t5_clr_count", 32'(digit_count), 0);
        back();
        check("t5_back0_err", 32'(entry_err),   0);
        digit(1); digit(2); digit(3); digit(4);
        step(0, 0, 1, 0, 0, 1);
        check("t5_lo_valid", 32'(valid),       0);
        check("t5_lo_count", 32'(digit_count), 0);

`ifdef USERID_TIMEOUT_EN
        // 6: idle timeout
        digit(3);
        repeat (TIMEOUT_CYC - 1) idle();
        check("t6_to_early", 32'(timeout),     0);
        idle();
        check("t6_to",       32'(timeout),     1);
        check("t6_count",    32'(digit_count), 0);
`endif
        // Reset mid-entry and while locked
        digit(6); digit(7);
        async_reset("t6_mid");
        digit(1); digit(2); digit(3); digit(4); enter();
        async_reset("t6_lock");

        // Random stimulus
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                repeat ($urandom_range(1, 12)) idle();
            end else if (r == 3) begin
                async_reset("rnd");
            end else begin
                step(($urandom_range(0, 99) < 45), int'($urandom_range(0, 15)),
                     ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 10),
                     ($urandom_range(0, 99) < 4),  ($urandom_range(0, 99) < 4));
            end
        end

        @(negedge clk);
        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
